// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, memory-wait freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 255
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W          = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt_addr,
    input  logic       ex_branch,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       pc_write_en,
    output logic       fd_write_en,
    output logic       fd_flush,
    output logic       dx_stall_b,
    output logic       pipe_freeze,
    output logic       mem_timeout,
    output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [CNT_W-1:0] wait_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0]  FLUSH_LOAD      = 3'(BRANCH_PENALTY - 1);
    localparam logic [15:0] TIMEOUT_VAL     = 16'(MEM_TIMEOUT);
    localparam bit          HAS_FLUSH_STATE = (BRANCH_PENALTY > 1);

    state_t      state_reg, state_next;
    logic [2:0]  flush_cnt_reg, flush_cnt_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        resume_flush_reg, resume_flush_next;
    logic        timeout_reg, timeout_next;

    logic lu;
    logic bt;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign lu = ex_mem_read && (ex_rt_addr != 5'd0) &&
                ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));
    assign bt = ex_branch && ex_branch_taken;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg        <= ST_RUN;
            flush_cnt_reg    <= 3'd0;
            wait_cnt_reg     <= 16'd0;
            resume_flush_reg <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            flush_cnt_reg    <= flush_cnt_next;
            wait_cnt_reg     <= wait_cnt_next;
            resume_flush_reg <= resume_flush_next;
            timeout_reg      <= timeout_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        flush_cnt_next    = flush_cnt_reg;
        wait_cnt_next     = wait_cnt_reg;
        resume_flush_next = resume_flush_reg;
        timeout_next      = timeout_reg;
        pc_write_en       = 1'b1;
        fd_write_en       = 1'b1;
        fd_flush          = 1'b0;
        dx_stall_b        = 1'b1;
        pipe_freeze       = 1'b0;

        unique case (state_reg)
            ST_RUN: begin
                if (mem_busy) begin
                    pipe_freeze       = 1'b1;
                    pc_write_en       = 1'b0;
                    fd_write_en       = 1'b0;
                    state_next        = ST_MEM_WAIT;
                    resume_flush_next = 1'b0;
                    wait_cnt_next     = 16'd0;
                end else if (bt) begin
                    // PC keeps loading so the branch target enters fetch this cycle.
                    fd_flush   = 1'b1;
                    dx_stall_b = 1'b0;
                    if (HAS_FLUSH_STATE) begin
                        flush_cnt_next = FLUSH_LOAD;
                        state_next     = ST_FLUSH;
                    end
                end else if (lu) begin
                    pc_write_en = 1'b0;
                    fd_write_en = 1'b0;
                    dx_stall_b  = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (mem_busy) begin
                    // Flush progress pauses; the count is kept for the resume.
                    pipe_freeze       = 1'b1;
                    pc_write_en       = 1'b0;
                    fd_write_en       = 1'b0;
                    state_next        = ST_MEM_WAIT;
                    resume_flush_next = 1'b1;
                    wait_cnt_next     = 16'd0;
                end else begin
                    fd_flush   = 1'b1;
                    dx_stall_b = 1'b0;
                    if (flush_cnt_reg <= 3'd1) begin
                        flush_cnt_next = 3'd0;
                        state_next     = ST_RUN;
                    end else begin
                        flush_cnt_next = flush_cnt_reg - 3'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                pipe_freeze = 1'b1;
                pc_write_en = 1'b0;
                fd_write_en = 1'b0;
                if (mem_busy) begin
                    if (wait_cnt_reg < TIMEOUT_VAL) begin
                        wait_cnt_next = wait_cnt_reg + 16'd1;
                    end
                    if (wait_cnt_reg >= TIMEOUT_VAL - 16'd1) begin
                        timeout_next = 1'b1;
                    end
                end else begin
                    wait_cnt_next = 16'd0;
                    state_next    = resume_flush_reg ? ST_FLUSH : ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // While reset is held the front end is parked on a NOP and nothing advances.
        if (!rst_b) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b0;
            fd_flush    = 1'b1;
            dx_stall_b  = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    assign mem_timeout = timeout_reg;
    assign ctrl_state  = state_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0] perf_evt;

    assign perf_evt[0] = (state_reg == ST_RUN) && !mem_busy && !bt && lu;
    assign perf_evt[1] = fd_flush && rst_b;
    assign perf_evt[2] = pipe_freeze;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    cnt_reg <= '0;
                end else if (perf_clr) begin
                    cnt_reg <= '0;
                end else if (perf_evt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cycles = g_perf[0].cnt_reg;
    assign flush_cycles = g_perf[1].cnt_reg;
    assign wait_cycles  = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: three controllers (BRANCH_PENALTY 1..3, MEM_TIMEOUT 4) share one stimulus stream.
// A remaining-flush-count model predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

    localparam int NI  = 3;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [4:0] id_rs_addr, id_rt_addr, ex_rt_addr;
    logic       id_uses_rt, ex_mem_read, ex_branch, ex_branch_taken, mem_busy;

    logic [NI-1:0] pc_write_en, fd_write_en, fd_flush, dx_stall_b, pipe_freeze, mem_timeout;
    logic [1:0]    ctrl_state [NI];

`ifdef HAZARD_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [31:0] stall_cycles [NI];
    logic [31:0] flush_cycles [NI];
    logic [31:0] wait_cycles  [NI];
`endif

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            pipeline_hazard_controller #(
                .BRANCH_PENALTY(gi + 1),
                .MEM_TIMEOUT   (TMO)
            ) dut (
                .clk            (clk),
                .rst_b          (rst_b),
                .id_rs_addr     (id_rs_addr),
                .id_rt_addr     (id_rt_addr),
                .id_uses_rt     (id_uses_rt),
                .ex_mem_read    (ex_mem_read),
                .ex_rt_addr     (ex_rt_addr),
                .ex_branch      (ex_branch),
                .ex_branch_taken(ex_branch_taken),
                .mem_busy       (mem_busy),
                .pc_write_en    (pc_write_en[gi]),
                .fd_write_en    (fd_write_en[gi]),
                .fd_flush       (fd_flush[gi]),
                .dx_stall_b     (dx_stall_b[gi]),
                .pipe_freeze    (pipe_freeze[gi]),
                .mem_timeout    (mem_timeout[gi]),
                .ctrl_state     (ctrl_state[gi])
`ifdef HAZARD_PERF_CNT_EN
                ,
                .perf_clr       (perf_clr),
                .stall_cycles   (stall_cycles[gi]),
                .flush_cycles   (flush_cycles[gi]),
                .wait_cycles    (wait_cycles[gi])
`endif
            );
        end
    endgenerate

    // Reference model state: flush cycles still owed, memory-wait bookkeeping, sticky timeout.
    int  flush_left [NI];
    bit  in_wait    [NI];
    int  wcnt       [NI];
    bit  tmo        [NI];

    logic [8*NI-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic logic [7:0] dut_vec(input int k);
        return {pc_write_en[k], fd_write_en[k], fd_flush[k], dx_stall_b[k],
                pipe_freeze[k], mem_timeout[k], ctrl_state[k]};
    endfunction

    task automatic model_push();
        logic [8*NI-1:0] e;
        bit lu_c, bt_c;
        logic [4:0] outs;
        logic [1:0] st;
        bit t_out;
        lu_c = ex_mem_read && (ex_rt_addr != 0) &&
               ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));
        bt_c = ex_branch && ex_branch_taken;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            // outs = {pc_write_en, fd_write_en, fd_flush, dx_stall_b, pipe_freeze}
            if (!rst_b) begin
                outs = 5'b00100; st = 2'd0; t_out = 1'b0;
                flush_left[k] = 0; in_wait[k] = 0; wcnt[k] = 0; tmo[k] = 0;
            end else begin
                t_out = tmo[k];
                if (in_wait[k]) begin
                    outs = 5'b00011; st = 2'd2;
                    if (mem_busy) begin
                        if (wcnt[k] < TMO) wcnt[k]++;
                        if (wcnt[k] == TMO) tmo[k] = 1;
                    end else begin
                        in_wait[k] = 0; wcnt[k] = 0;
                    end
                end else if (mem_busy) begin
                    outs = 5'b00011; st = (flush_left[k] > 0) ? 2'd1 : 2'd0;
                    in_wait[k] = 1; wcnt[k] = 0;
                end else if (flush_left[k] > 0) begin
                    outs = 5'b11100; st = 2'd1;
                    flush_left[k]--;
                end else begin
                    st = 2'd0;
                    if (bt_c) begin
                        outs = 5'b11100; flush_left[k] = k; // penalty (k+1) minus detection cycle
                    end else if (lu_c) begin
                        outs = 5'b00000;
                    end else begin
                        outs = 5'b11010;
                    end
                end
            end
            e[k*8 +: 8] = {outs, t_out, st};
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_push();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic mr, input logic [4:0] xrt, input logic br,
                          input logic tk, input logic busy);
        id_rs_addr = rs; id_rt_addr = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rt_addr = xrt; ex_branch = br;
        ex_branch_taken = tk; mem_busy = busy;
    endtask

    initial begin : monitor
        logic [8*NI-1:0] e;
        int mcyc;
        mcyc = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mcyc++;
                for (int k = 0; k < NI; k++) begin
                    checks++;
                    if (dut_vec(k) !== e[k*8 +: 8]) begin
                        errors++;
                        $display("FAIL outvec bp%0d cyc %0d got %b want %b (pc fd flush stall_b freeze tmo state)",
                                 k + 1, mcyc, dut_vec(k), e[k*8 +: 8]);
                    end
                end
                $display("cyc %0d rst_b=%0b busy=%0b states=%0d/%0d/%0d", mcyc, rst_b, mem_busy,
                         ctrl_state[0], ctrl_state[1], ctrl_state[2]);
            end
        end
    end

    initial begin : stim
        rst_b = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst_b = 1'b1;
        repeat (2) tick();

        // Load-use: matching rs, register 0, rt match without/with rt use.
        set_in(5, 0, 0, 1, 5, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 1, 0, 0, 0, 0); tick();
        set_in(1, 5, 0, 1, 5, 0, 0, 0); tick();
        set_in(1, 5, 1, 1, 5, 0, 0, 0); tick(); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Branch pulse, then not-taken branch.
        set_in(0, 0, 0, 0, 0, 1, 1, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();
        set_in(0, 0, 0, 0, 0, 1, 0, 0); tick();

        // Reset asserted mid-flush.
        set_in(0, 0, 0, 0, 0, 1, 1, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); rst_b = 1'b0; tick();
        rst_b = 1'b1; repeat (3) tick();

        // Priority: mem_busy beats bt beats lu; branch honoured after release.
        set_in(5, 0, 0, 1, 5, 1, 1, 1); tick(); tick();
        set_in(5, 0, 0, 1, 5, 1, 1, 0); tick(); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (4) tick();

        // Memory wait inside a flush.
        set_in(0, 0, 0, 0, 0, 1, 1, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1); repeat (3) tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (5) tick();

        // Timeout: six busy cycles, flag stays set until reset.
        set_in(0, 0, 0, 0, 0, 0, 0, 1); repeat (6) tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();
        rst_b = 1'b0; tick();
        rst_b = 1'b1; tick();

        for (int i = 0; i < 2000; i++) begin
            rst_b = ($urandom_range(0, 299) != 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) < 3));
            tick();
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
